// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and sizing helpers for the UART receiver
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per oversample tick
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  // Bits needed to hold values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO with drop indication
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A pop on the same cycle frees the slot, so a push into a full FIFO is still taken
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & ~do_push;

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

  // Storage write; contents need no reset since the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver with receive FIFO
module uart_rx_cfg import uart_pkg::*; #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 overrun_err,
  output logic                 break_det,
  input  logic                 err_clr
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W  = cnt_width(DIV);
  localparam int OS_W   = cnt_width(OVERSAMPLE);
  localparam int BIT_W  = cnt_width(DATA_BITS);
  localparam int WORD_W = DATA_BITS + 2;

  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] SAMP_A  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP_B  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SAMP_C  = OS_W'(OVERSAMPLE / 2 + 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_cfg: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_cfg: OVERSAMPLE must be even, 8..16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
    end
  endgenerate

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  rx_state_e            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d, cur_cnt;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_one_q, stop_one_d;
  logic                 arm_q, arm_d;
  logic                 overrun_q, overrun_d;
  logic                 maj, at_maj, bit_end;
  logic                 push, brk_pulse, fifo_drop;
  logic [WORD_W-1:0]    push_word, head_word;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer on the asynchronous line, idling high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx_line};
  end

  assign tick = (div_q == DIV_W'(DIV - 1));

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // os_cnt_q holds the count of the last consumed tick; cur_cnt is this tick's count
  assign cur_cnt = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign at_maj  = tick && (cur_cnt == SAMP_C);
  assign bit_end = tick && (cur_cnt == '0);

  assign push_word = {ferr_q | ~maj, perr_q, data_q};

  // Next-state logic: start hunting, bit sampling, parity/stop evaluation and push
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_one_d = stop_one_q;
    // A new start needs the line to have been seen high, so a held-low line is not re-read
    arm_d      = arm_q | rx_s;
    push       = 1'b0;
    brk_pulse  = 1'b0;

    if (state_q != ST_IDLE && tick) begin
      os_cnt_d = cur_cnt;
      if (cur_cnt == SAMP_A) samp_d[0] = rx_s;
      if (cur_cnt == SAMP_B) samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick && !rx_s && arm_q) begin
          state_d    = ST_START;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          par_bit_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop_one_d = 1'b0;
          arm_d      = 1'b0;
        end
      end
      ST_START: begin
        if (at_maj && maj)  state_d = ST_IDLE;
        else if (bit_end)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_maj) data_d = {maj, data_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (at_maj) begin
          par_bit_d = maj;
          perr_d    = (((^data_q) ^ maj) != (PARITY == PAR_ODD));
        end
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (at_maj) begin
          if (!maj) ferr_d = 1'b1;
          else      stop_one_d = 1'b1;
          // Push at mid-stop and leave at once so the next start edge is caught
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            push      = 1'b1;
            brk_pulse = (data_q == '0) && !par_bit_q && !stop_one_q && !maj;
            state_d   = ST_IDLE;
            arm_d     = 1'b0;
          end
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= 2'b00;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_one_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_one_q <= stop_one_d;
      arm_q      <= arm_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (rx_ready),
    .data_o      (head_word),
    .valid_o     (rx_valid),
    .drop_o      (fifo_drop)
  );

  // A new drop wins over a simultaneous clear
  assign overrun_d = fifo_drop ? 1'b1 : (err_clr ? 1'b0 : overrun_q);

  // Sticky overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign {rx_frame_err, rx_parity_err, rx_data} = head_word;
  assign rx_busy     = (state_q != ST_IDLE);
  assign overrun_err = overrun_q;
  assign break_det   = brk_pulse;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit (even, 8..16).
REQ-004 The block SHALL have parameter DATA_BITS, default 8, meaning payload width (5..9).
REQ-005 The block SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-006 The block SHALL have parameter STOP_BITS, default 1, meaning stop-bit count (1 or 2).
REQ-007 The block SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, >=2).
REQ-008 The block SHALL have the following ports:
  clk  input  1  system clock; one clock only
  reset_n  input  1  asynchronous, active-low reset
  rx_line  input  1  asynchronous serial input, idle high
  rx_data  output  DATA_BITS  FIFO head payload
  rx_frame_err  output  1  FIFO head stop-bit error flag
  rx_parity_err  output  1  FIFO head parity error flag
  rx_valid  output  1  FIFO non-empty
  rx_ready  input  1  consumer accepts head when rx_valid & rx_ready
  rx_busy  output  1  frame in progress
  overrun_err  output  1  sticky: frame dropped because FIFO full
  break_det  output  1  one-cycle pulse on break frame
  err_clr  input  1  clears overrun_err

Function
REQ-009 rx_line SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-010 A sample tick SHALL fire once every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks; the tick counter runs freely.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-012 In IDLE: a synchronized low sampled on a tick SHALL enter START with the tick count at 0 and assert rx_busy.
REQ-013 Each bit value SHALL be the majority of the samples at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2, and OVERSAMPLE/2+1.
REQ-014 In START: a majority value of 1 SHALL be a false start, returning to IDLE with rx_busy cleared and nothing pushed. A majority value of 0 SHALL enter DATA once OVERSAMPLE ticks have elapsed.
REQ-015 In DATA: DATA_BITS bits SHALL be received LSB first. The FSM SHALL then enter PARITY if PARITY != 0, otherwise STOP.
REQ-016 In PARITY: parity_err SHALL be set when the XOR of the data bits and the parity bit is not 1 (odd mode) or not 0 (even mode). With PARITY=0, parity_err SHALL be 0.
REQ-017 In STOP: each stop bit SHALL be evaluated at its majority point. frame_err SHALL be set if any stop bit is 0.
REQ-018 At the majority point of the last stop bit, the {frame_err, parity_err, data} word SHALL be pushed, and the FSM SHALL return to IDLE on the same cycle with rx_busy low. It SHALL NOT wait for the end of the bit, so that resync on the next start edge is possible.
REQ-019 break_det SHALL pulse for 1 cycle coincident with the push when all data bits, the parity bit (if any), and all stop bits are 0.
REQ-020 The FIFO SHALL be show-ahead: rx_valid and the head outputs SHALL be valid 1 clock after a push into an empty FIFO.
REQ-021 A pop SHALL occur when rx_valid & rx_ready; the next entry SHALL be presented on the following clock.
REQ-022 Push while full without a simultaneous pop: the frame SHALL be dropped and overrun_err set. Push while full with a simultaneous pop: the push SHALL be accepted and no error raised.
REQ-023 Pop while empty SHALL be ignored. Pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be derived from a count of 0..FIFO_DEPTH.
REQ-024 overrun_err SHALL stay set until err_clr. err_clr coincident with a new overrun SHALL leave overrun_err set.
REQ-025 Illegal parameter values SHALL be rejected at elaboration, including DIV < 1.

Reset
REQ-026 On reset_n low, the following SHALL be asynchronously forced:
  FSM IDLE; all counters 0; FIFO empty
  rx_valid=0, rx_busy=0, overrun_err=0, break_det=0
  rx_data=0, rx_frame_err=0, rx_parity_err=0
  synchronizer=1
REQ-027 Reset asserted mid-frame SHALL discard the partial frame. After release, the block SHALL wait for a new falling edge and SHALL NOT resume the interrupted frame.

Structure
REQ-028 Parity-mode encodings and FSM state encodings SHALL live in a shared package (uart_pkg), together with the localparam functions for DIV and counter widths.
REQ-029 The FIFO SHALL be a sub-module, uart_rx_fifo, parametrised by width and depth.

Verification (bench: CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving DIV=10 and 160 clk/bit)
REQ-030 8N1 frame 0xA5, no consumer -> rx_valid rises 1 clk after the mid-stop point, rx_data=0xA5, both error flags 0.
REQ-031 DATA_BITS=7, PARITY=2: frame 0x55 with correct parity bit 0 -> parity_err 0. The same frame with parity bit 1 -> 0x55 with parity_err 1.
REQ-032 Low glitch of 40 clk on an idle line -> false start, rx_busy falls, nothing pushed.
REQ-033 Nine frames 0x01..0x09 with rx_ready=0 (depth 8) -> overrun_err=1, FIFO holds 0x01..0x08. err_clr clears the flag. Popping 8 times yields the values in order, then rx_valid=0.
REQ-034 Line held low for 12 bit times -> break_det pulses once, and a word with data 0x00 and frame_err 1 is pushed. A second frame 0x3C after the line returns high is received correctly.
REQ-035 reset_n pulsed low at data bit 4 of 0xFF -> all outputs at reset values. A following frame 0x81 is received cleanly.
